// File: rtl/pwm_duty_loader_if.sv
// Write-side bus for pwm_duty_loader: per-channel (chan, ton, oe) updates from
// the CPU register side, using a valid/ready handshake.
interface pwm_duty_loader_if #(
    parameter int CHAN_W    = 5,
    parameter int TON_WIDTH = 10
) ();
    logic                 wr_valid;
    logic                 wr_ready;
    logic [CHAN_W-1:0]    wr_chan;
    logic [TON_WIDTH-1:0] wr_ton;
    logic                 wr_oe;

    modport master (
        output wr_valid,
        output wr_chan,
        output wr_ton,
        output wr_oe,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_chan,
        input  wr_ton,
        input  wr_oe,
        output wr_ready
    );
endinterface

// File: rtl/pwm_duty_loader.sv
// Update FIFO and replay sequencer feeding the multi-PWM bank: one queued
// channel update every 3 cycles, optionally gated to a PWM period boundary.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a queued entry and drain permission
// S_SETUP  | drive ton_out and oe_out for the popped entry
// S_STROBE | raise the channel latch (registered, seen next cycle)
// S_HOLD   | latch low, ton held; pop next entry or return to idle
module pwm_duty_loader #(
    parameter int NB_CHAN    = 24,
    parameter int TON_WIDTH  = 10,
    parameter int CHAN_W     = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    pwm_duty_loader_if.slave     wr,
    input  logic                 sync_en,
    input  logic                 period_start,
    input  logic                 err_clr,
    output logic [TON_WIDTH-1:0] ton_out,
    output logic [NB_CHAN-1:0]   latch_out,
    output logic [NB_CHAN-1:0]   oe_out,
    output logic                 busy,
    output logic                 overflow_err,
    output logic                 bad_chan_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [31:0]   NB_CHAN_C = 32'(NB_CHAN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    typedef struct packed {
        logic [CHAN_W-1:0]    chan;
        logic [TON_WIDTH-1:0] ton;
        logic                 oe;
    } entry_t;

    state_t               state_q, state_d;
    entry_t               mem_q [FIFO_DEPTH];
    entry_t               mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    entry_t               cur_q, cur_d;
    logic [TON_WIDTH-1:0] ton_q, ton_d;
    logic [NB_CHAN-1:0]   latch_q, latch_d;
    logic [NB_CHAN-1:0]   oe_q, oe_d;
    logic                 armed_q, armed_d;
    logic                 ovf_q, ovf_d;
    logic                 bad_q, bad_d;

    logic full;
    logic empty;
    logic allow;
    logic push;
    logic pop;
    logic decide;
    logic cur_valid;

    // Readiness depends only on the registered fill level, never on a same-cycle pop.
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign allow     = !sync_en || armed_q;
    assign push      = wr.wr_valid && !full;
    assign cur_valid = (32'(cur_q.chan) < NB_CHAN_C);

    assign wr.wr_ready  = !full;
    assign ton_out      = ton_q;
    assign latch_out    = latch_q;
    assign oe_out       = oe_q;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign overflow_err = ovf_q;
    assign bad_chan_err = bad_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        decide  = 1'b0;
        case (state_q)
            S_IDLE: begin
                decide = 1'b1;
                if (!empty && allow) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: state_d = S_HOLD;
            S_HOLD: begin
                decide = 1'b1;
                if (!empty && allow) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{chan: wr.wr_chan, ton: wr.wr_ton, oe: wr.wr_oe};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        cur_d   = pop ? mem_q[rd_ptr_q] : cur_q;
        ton_d   = ton_q;
        oe_d    = oe_q;
        latch_d = '0;
        bad_d   = bad_q;
        ovf_d   = ovf_q;
        armed_d = armed_q;

        if (state_q == S_SETUP) begin
            ton_d = cur_q.ton;
            for (int i = 0; i < NB_CHAN; i++) begin
                if (cur_valid && (cur_q.chan == CHAN_W'(i))) begin
                    oe_d[i] = cur_q.oe;
                end
            end
        end

        // Out-of-range channels are consumed silently apart from the sticky flag.
        if (state_q == S_STROBE) begin
            if (cur_valid) begin
                for (int i = 0; i < NB_CHAN; i++) begin
                    latch_d[i] = (cur_q.chan == CHAN_W'(i));
                end
            end else begin
                bad_d = 1'b1;
            end
        end

        if (wr.wr_valid && full) begin
            ovf_d = 1'b1;
        end
        if (err_clr) begin
            ovf_d = 1'b0;
            bad_d = 1'b0;
        end

        // A period boundary re-arms even if the queue ran dry that same cycle.
        if (decide && empty) begin
            armed_d = 1'b0;
        end
        if (sync_en && period_start) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            ton_q    <= '0;
            latch_q  <= '0;
            oe_q     <= '0;
            armed_q  <= 1'b0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
            ton_q    <= ton_d;
            latch_q  <= latch_d;
            oe_q     <= oe_d;
            armed_q  <= armed_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
        end
    end

endmodule

// File: tb/tb_pwm_duty_loader.sv
// Directed bench for pwm_duty_loader: hand-computed expectations checked with
// immediate assertions after each clock edge.
module tb_pwm_duty_loader;

    logic        clk;
    logic        reset_n;
    logic        sync_en;
    logic        period_start;
    logic        err_clr;
    logic [9:0]  ton_out;
    logic [23:0] latch_out;
    logic [23:0] oe_out;
    logic        busy;
    logic        overflow_err;
    logic        bad_chan_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt;

    pwm_duty_loader_if #(.CHAN_W(5), .TON_WIDTH(10)) wr_if ();

    pwm_duty_loader #(
        .NB_CHAN(24), .TON_WIDTH(10), .CHAN_W(5), .FIFO_DEPTH(8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wr_if),
        .sync_en      (sync_en),
        .period_start (period_start),
        .err_clr      (err_clr),
        .ton_out      (ton_out),
        .latch_out    (latch_out),
        .oe_out       (oe_out),
        .busy         (busy),
        .overflow_err (overflow_err),
        .bad_chan_err (bad_chan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int ch, input int ton, input logic oe);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_chan  = 5'(ch);
        wr_if.wr_ton   = 10'(ton);
        wr_if.wr_oe    = oe;
        tick();
        wr_if.wr_valid = 1'b0;
    endtask

    task automatic count_strobes(input int cycles, input int base, input int step, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (latch_out != '0) begin
                chk("latch_strobe", {8'h0, latch_out}, 32'(1) << (base + n * step));
                n++;
            end
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        sync_en        = 1'b0;
        period_start   = 1'b0;
        err_clr        = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_chan  = '0;
        wr_if.wr_ton   = '0;
        wr_if.wr_oe    = 1'b0;
        tick(2);
        chk("rst_ton",      32'(ton_out),      32'h0);
        chk("rst_latch",    32'(latch_out),    32'h0);
        chk("rst_oe",       32'(oe_out),       32'h0);
        chk("rst_busy",     32'(busy),         32'h0);
        chk("rst_ready",    32'(wr_if.wr_ready), 32'h1);
        chk("rst_ovf",      32'(overflow_err), 32'h0);
        chk("rst_bad",      32'(bad_chan_err), 32'h0);
        reset_n = 1'b1;
        tick();

        // 1: immediate drain, strobe 3 cycles after the push
        push(3, 200, 1'b1);
        tick(2);
        chk("t1_ton_pre",   32'(ton_out),   32'd200);
        chk("t1_latch_pre", 32'(latch_out), 32'h0);
        tick();
        chk("t1_latch",     32'(latch_out), 32'h8);
        chk("t1_oe",        32'(oe_out),    32'h8);
        tick();
        chk("t1_latch_off", 32'(latch_out), 32'h0);
        chk("t1_busy_off",  32'(busy),      32'h0);

        // 2: sync mode waits for period_start
        sync_en = 1'b1;
        push(0, 10, 1'b1);
        push(23, 1023, 1'b1);
        count_strobes(5, 0, 0, cnt);
        chk("t2_no_strobe", 32'(cnt),  32'd0);
        chk("t2_busy",      32'(busy), 32'h1);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        tick(2);
        chk("t2_ton0",      32'(ton_out),   32'd10);
        tick();
        chk("t2_latch0",    32'(latch_out), 32'h1);
        tick(3);
        chk("t2_latch23",   32'(latch_out), 32'h800000);
        chk("t2_ton23",     32'(ton_out),   32'd1023);
        chk("t2_oe",        32'(oe_out),    32'h800009);
        tick(2);
        chk("t2_busy_off",  32'(busy),      32'h0);

        // 3: fill to 8, ninth push dropped, err_clr beats a same-cycle overflow
        for (int i = 0; i < 8; i++) push(i, i * 10 + 1, 1'(i % 2));
        chk("t3_ready_full", 32'(wr_if.wr_ready), 32'h0);
        chk("t3_ovf_pre",    32'(overflow_err),   32'h0);
        push(8, 81, 1'b0);
        chk("t3_ovf",        32'(overflow_err),   32'h1);
        err_clr = 1'b1;
        push(9, 91, 1'b1);
        err_clr = 1'b0;
        chk("t3_ovf_clr",    32'(overflow_err),   32'h0);
        chk("t3_busy",       32'(busy),           32'h1);
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
        count_strobes(30, 0, 1, cnt);
        chk("t3_strobes",    32'(cnt),            32'd8);
        chk("t3_ton_last",   32'(ton_out),        32'd71);
        chk("t3_oe",         32'(oe_out),         32'h8000AA);
        chk("t3_ready",      32'(wr_if.wr_ready), 32'h1);
        chk("t3_busy_off",   32'(busy),           32'h0);

        // 4: out-of-range channel
        sync_en = 1'b0;
        push(30, 5, 1'b1);
        tick(3);
        chk("t4_latch",     32'(latch_out),    32'h0);
        chk("t4_bad",       32'(bad_chan_err), 32'h1);
        chk("t4_oe",        32'(oe_out),       32'h8000AA);
        chk("t4_ton",       32'(ton_out),      32'd5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_bad_clr",   32'(bad_chan_err), 32'h0);

        // 5: reset while in STROBE with another entry queued
        push(2, 50, 1'b1);
        push(4, 60, 1'b1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("t5_latch",     32'(latch_out),       32'h0);
        chk("t5_oe",        32'(oe_out),          32'h0);
        chk("t5_ton",       32'(ton_out),         32'h0);
        chk("t5_busy",      32'(busy),            32'h0);
        chk("t5_ready",     32'(wr_if.wr_ready),  32'h1);
        tick();
        reset_n = 1'b1;
        count_strobes(8, 0, 0, cnt);
        chk("t5_no_strobe", 32'(cnt),    32'd0);
        chk("t5_busy_off",  32'(busy),   32'h0);
        chk("t5_oe_after",  32'(oe_out), 32'h0);

        // 6: two updates to the same channel, last one wins
        push(5, 100, 1'b1);
        push(5, 300, 1'b0);
        count_strobes(10, 5, 0, cnt);
        chk("t6_strobes",   32'(cnt),       32'd2);
        chk("t6_ton",       32'(ton_out),   32'd300);
        chk("t6_oe5",       32'(oe_out[5]), 32'h0);
        chk("t6_busy_off",  32'(busy),      32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
